ae350_aopd_rst_seq: RTL

Parametrised reset sequencer for the always-on power domain, clocked by `clk_32k`. It releases `NUM_CH` downstream active-low resets in a fixed order, spacing each release by a programmable number of cycles. It also accepts per-channel re-reset requests: the requested channel and every later channel are re-asserted for a minimum width, then re-released in order. It sits after the POR/debug-reset mix and drives the AOPD peripheral and bridge resets.

---
 rtl/ae350_aopd_rst_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ae350_aopd_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : ae350_aopd_rst_seq
// Purpose  : Always-on power-domain reset sequencer. Releases NUM_CH
//            active-low resets in order (bit 0 first), spaced by STEP_CYC
//            cycles. A re-reset request on channel k re-asserts channel k and
//            all higher channels for at least MIN_ASSERT cycles, then
//            re-releases them in order.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   NUM_CH     - number of sequenced channels (1..16)
//   STEP_CYC   - cycles between consecutive releases (>=1)
//   MIN_ASSERT - minimum re-assertion width in cycles (>=1)
// Ports:
//   clk_32k          in   always-on 32 kHz clock
//   por_dbg_mix_rstn in   asynchronous active-low reset
//   rst_req          in   per-channel level re-reset request
//   test_mode        in   scan/test mode select
//   test_rstn        in   test reset driven out while bypass is active
//   rst_out_n        out  sequenced active-low resets
//   seq_done         out  high while every channel is released
//   last_req_ch      out  channel index of the most recent re-reset
// Configuration macro:
//   AE350_AOPD_RST_SEQ_TEST_BYPASS_EN - when defined, test_mode=1 forces all
//   outputs from test_rstn; when undefined test_mode/test_rstn are unused.
// ============================================================================
module ae350_aopd_rst_seq #(
  parameter int NUM_CH     = 4,
  parameter int STEP_CYC   = 4,
  parameter int MIN_ASSERT = 8
) (
  input  logic                                     clk_32k,
  input  logic                                     por_dbg_mix_rstn,
  input  logic [NUM_CH-1:0]                        rst_req,
  input  logic                                     test_mode,
  input  logic                                     test_rstn,
  output logic [NUM_CH-1:0]                        rst_out_n,
  output logic                                     seq_done,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] last_req_ch
);

  localparam int PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_MAX = (STEP_CYC > MIN_ASSERT) ? STEP_CYC : MIN_ASSERT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] STEP_RLD = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_RLD = CNT_W'(MIN_ASSERT - 1);
  localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(NUM_CH - 1);

  localparam logic [1:0] ST_RELEASE = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0]        state_q,    state_d;
  logic [PTR_W-1:0]  ptr_q,      ptr_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [NUM_CH-1:0] rst_out_q,  rst_out_d;
  logic              seq_done_q, seq_done_d;
  logic [PTR_W-1:0]  last_q,     last_d;

  logic              req_any_w;
  logic [PTR_W-1:0]  req_idx_w;
  logic              req_qual_w;

  // Lowest set request bit wins; scanning downward lets the lowest index
  // overwrite any higher one.
  always_comb begin
    req_any_w = |rst_req;
    req_idx_w = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rst_req[i]) req_idx_w = PTR_W'(i);
    end
  end

  // While releasing, only channels already released (below ptr) can be
  // re-reset; higher channels are still held in reset anyway.
  always_comb begin
    case (state_q)
      ST_RELEASE: req_qual_w = req_any_w && (req_idx_w < ptr_q);
      default:    req_qual_w = req_any_w;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    rst_out_d  = rst_out_q;
    seq_done_d = seq_done_q;
    last_d     = last_q;

    if (req_qual_w) begin
      // A request outranks any release due on the same edge.
      for (int i = 0; i < NUM_CH; i++) begin
        if (i >= int'(req_idx_w)) rst_out_d[i] = 1'b0;
      end
      seq_done_d = 1'b0;
      if ((state_q == ST_DONE) || (req_idx_w < ptr_q)) ptr_d = req_idx_w;
      last_d  = req_idx_w;
      cnt_d   = HOLD_RLD;
      state_d = ST_HOLD;
    end else begin
      case (state_q)
        ST_RELEASE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            rst_out_d[ptr_q] = 1'b1;
            cnt_d            = STEP_RLD;
            if (ptr_q == LAST_CH) begin
              state_d    = ST_DONE;
              seq_done_d = 1'b1;
            end else begin
              ptr_d = ptr_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_d = ST_RELEASE;
            cnt_d   = STEP_RLD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_DONE: ;
        default: begin
          state_d = ST_RELEASE;
          cnt_d   = STEP_RLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk_32k or negedge por_dbg_mix_rstn) begin
    if (!por_dbg_mix_rstn) begin
      state_q    <= ST_RELEASE;
      ptr_q      <= '0;
      cnt_q      <= STEP_RLD;
      rst_out_q  <= '0;
      seq_done_q <= 1'b0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      rst_out_q  <= rst_out_d;
      seq_done_q <= seq_done_d;
      last_q     <= last_d;
    end
  end

  assign last_req_ch = last_q;

`ifdef AE350_AOPD_RST_SEQ_TEST_BYPASS_EN
  // In test mode the sequencer keeps running but is hidden behind test_rstn.
  assign rst_out_n = test_mode ? {NUM_CH{test_rstn}} : rst_out_q;
  assign seq_done  = test_mode ? test_rstn : seq_done_q;
`else
  logic unused_test_w;
  assign unused_test_w = test_mode ^ test_rstn;
  assign rst_out_n     = rst_out_q;
  assign seq_done      = seq_done_q;
`endif

endmodule
`default_nettype wire
